// File: rtl/axis_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and the future receiver:
//   frame state encoding, data width, and small helper functions.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clock cycles per bit period (truncating integer division).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/axis_uart_tx_if.sv
// -----------------------------------------------------------------------------
// axis_if
//   Byte-wide AXI-stream style handshake bundle.
//   data : payload byte (source -> sink)
//   vld  : payload valid (source -> sink)
//   rdy  : sink ready    (sink -> source); a transfer happens when vld & rdy
//   master modport is the byte source, slave modport is the byte sink.
// -----------------------------------------------------------------------------
interface axis_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      vld;
  logic                      rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);

endinterface

// File: rtl/axis_uart_tx_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
//   Free-running bit-period counter, 0 .. CLKS_PER_BIT-1.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : reload 0 (used on every frame state change)
//   tick : 1 on the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Bit-period counter: reload on reset/clear, wrap at the bit boundary.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// -----------------------------------------------------------------------------
// axis_uart_tx
//   UART transmitter draining a byte stream onto a serial line, LSB first,
//   8 data bits, optional even parity, STOP_BITS stop bits.
//   clk    : clock
//   rst    : synchronous active-high reset; aborts any frame in flight
//   axis_i : byte input (slave side); rdy only while idle and out of reset
//   tx     : serial line, registered, idles high
//   busy   : 1 while a frame is being shifted out
// Build option: define AXIS_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
// -----------------------------------------------------------------------------
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int STOP_BITS   = 1
) (
  input  logic   clk,
  input  logic   rst,
  axis_if.slave  axis_i,
  output logic   tx,
  output logic   busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] ST_STOP   = STOP;

  localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("axis_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("axis_uart_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]                state_r;
  logic [2:0]                state_nxt_s;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [2:0]                bit_cnt_r;
  logic                      tx_r;
  logic                      busy_r;
  logic                      tick_s;
  logic                      clr_s;
  logic                      ok_s;
`ifdef AXIS_UART_TX_PARITY_EN
  logic                      parity_r;
`endif

  assign axis_i.rdy = (state_r == ST_IDLE) & ~rst;
  assign ok_s       = axis_i.vld & axis_i.rdy;
  // Baud timing restarts at every state change so each bit is exactly one period.
  assign clr_s      = (state_nxt_s != state_r);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Frame sequencing: next state from the current state and bit boundaries.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ok_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (bit_cnt_r == LAST_DATA_BIT)) begin
`ifdef AXIS_UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef AXIS_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s && (bit_cnt_r == LAST_STOP_BIT)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and line driver: tx is loaded with the level of the bit about
  // to start, so it changes in the same cycle as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {UART_DATA_BITS{1'b0}};
      bit_cnt_r <= 3'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (ok_s) begin
            shift_r   <= axis_i.data;
            bit_cnt_r <= 3'd0;
            tx_r      <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
            parity_r  <= even_parity(axis_i.data);
`endif
          end else begin
            tx_r <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            tx_r <= shift_r[0];
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            shift_r   <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
            // Wraps 7 -> 0 on the last data bit, ready to count stop bits.
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == LAST_DATA_BIT) begin
`ifdef AXIS_UART_TX_PARITY_EN
              tx_r <= parity_r;
`else
              tx_r <= 1'b1;
`endif
            end else begin
              tx_r <= shift_r[1];
            end
          end
        end
`ifdef AXIS_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick_s) begin
            tx_r <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          tx_r <= 1'b1;
          if (tick_s) begin
            if (bit_cnt_r == LAST_STOP_BIT) begin
              bit_cnt_r <= 3'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        default: begin
          tx_r <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_axis_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_axis_uart_tx
//   Directed bench for axis_uart_tx at 10 clocks per bit. DUT a uses one stop
//   bit, DUT b uses two. Inputs change and outputs are sampled on the falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_axis_uart_tx;

  localparam int CPB = 10;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_A = (1 + 8 + P + 1) * CPB;
  localparam int FRAME_B = (1 + 8 + P + 2) * CPB;

  logic clk;
  logic rst;
  logic tx_a, busy_a, tx_b, busy_b;

  axis_if ax_a ();
  axis_if ax_b ();

  int n_checks;
  int n_fail;

  axis_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .axis_i(ax_a), .tx(tx_a), .busy(busy_a)
  );

  axis_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .axis_i(ax_b), .tx(tx_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level during bit slot k of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if ((P == 1) && (k == 9)) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (ax_a.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", ax_a.rdy); end
    n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_checks++; if (tx_b !== 1'b1) begin n_fail++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
    rst = 1'b0;
    #1;
    n_checks++; if (ax_a.rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_after: got %b expected 1", ax_a.rdy); end
  endtask

  task automatic test_single_byte;
    @(negedge clk);
    ax_a.data = 8'h55; ax_a.vld = 1'b1;
    n_checks++; if (ax_a.rdy !== 1'b1) begin n_fail++; $display("FAIL t1_rdy: got %b expected 1", ax_a.rdy); end
    @(negedge clk);
    ax_a.vld = 1'b0;
    n_checks++; if (ax_a.rdy !== 1'b0) begin n_fail++; $display("FAIL t1_handshake_rdy: got %b expected 0", ax_a.rdy); end
    for (int c = 0; c < FRAME_A; c++) begin
      n_checks++;
      if (tx_a !== exp_bit(8'h55, c / CPB)) begin n_fail++; $display("FAIL t1_tx cycle %0d: got %b expected %b", c, tx_a, exp_bit(8'h55, c / CPB)); end
      n_checks++;
      if (busy_a !== 1'b1) begin n_fail++; $display("FAIL t1_busy cycle %0d: got %b expected 1", c, busy_a); end
      @(negedge clk);
    end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t1_busy_end: got %b expected 0", busy_a); end
    n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL t1_tx_end: got %b expected 1", tx_a); end
  endtask

  task automatic test_back_to_back;
    logic tx_log [256];
    logic rdy_log [256];
    logic [7:0] b1, b2;
    int rdy_hi, j2;
    @(negedge clk);
    ax_a.data = 8'hA5; ax_a.vld = 1'b1;
    @(negedge clk);
    ax_a.data = 8'h3C;
    for (int i = 0; i <= 2 * FRAME_A; i++) begin
      tx_log[i] = tx_a;
      rdy_log[i] = ax_a.rdy;
      if (i == FRAME_A + 1) ax_a.vld = 1'b0;
      @(negedge clk);
    end
    rdy_hi = 0;
    for (int i = 0; i < FRAME_A; i++) if (rdy_log[i] !== 1'b0) rdy_hi++;
    n_checks++; if (rdy_hi != 0) begin n_fail++; $display("FAIL t2_rdy_low: got %0d ready cycles expected 0", rdy_hi); end
    n_checks++; if (rdy_log[FRAME_A] !== 1'b1) begin n_fail++; $display("FAIL t2_rdy_idle: got %b expected 1", rdy_log[FRAME_A]); end
    j2 = -1;
    for (int i = (9 + P) * CPB; i <= 2 * FRAME_A; i++) if ((j2 < 0) && (tx_log[i] === 1'b0)) j2 = i;
    n_checks++; if (j2 != 101 + P * CPB) begin n_fail++; $display("FAIL t2_spacing: got %0d expected %0d", j2, 101 + P * CPB); end
    for (int k = 0; k < 8; k++) begin
      b1[k] = tx_log[(k + 1) * CPB + CPB / 2];
      b2[k] = tx_log[FRAME_A + 1 + (k + 1) * CPB + CPB / 2];
    end
    n_checks++; if (b1 !== 8'hA5) begin n_fail++; $display("FAIL t2_byte1: got %h expected a5", b1); end
    n_checks++; if (b2 !== 8'h3C) begin n_fail++; $display("FAIL t2_byte2: got %h expected 3c", b2); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t2_busy_end: got %b expected 0", busy_a); end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    ax_a.data = 8'hFF; ax_a.vld = 1'b1;
    @(negedge clk);
    ax_a.vld = 1'b0;
    repeat (45) @(negedge clk);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL t3_busy_mid: got %b expected 1", busy_a); end
    rst = 1'b1;
    #1;
    n_checks++; if (ax_a.rdy !== 1'b0) begin n_fail++; $display("FAIL t3_rdy_in_rst: got %b expected 0", ax_a.rdy); end
    @(negedge clk);
    n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL t3_tx_abort: got %b expected 1", tx_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t3_busy_abort: got %b expected 0", busy_a); end
    n_checks++; if (ax_a.rdy !== 1'b0) begin n_fail++; $display("FAIL t3_rdy_rst_hold: got %b expected 0", ax_a.rdy); end
    rst = 1'b0;
    #1;
    n_checks++; if (ax_a.rdy !== 1'b1) begin n_fail++; $display("FAIL t3_rdy_after: got %b expected 1", ax_a.rdy); end
    @(negedge clk);
    ax_a.data = 8'h81; ax_a.vld = 1'b1;
    @(negedge clk);
    ax_a.vld = 1'b0;
    for (int c = 0; c < FRAME_A; c++) begin
      n_checks++;
      if (tx_a !== exp_bit(8'h81, c / CPB)) begin n_fail++; $display("FAIL t3_tx cycle %0d: got %b expected %b", c, tx_a, exp_bit(8'h81, c / CPB)); end
      @(negedge clk);
    end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t3_busy_end: got %b expected 0", busy_a); end
  endtask

  task automatic test_idle_hold;
    ax_a.data = 8'hC3; ax_a.vld = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL t4_tx cycle %0d: got %b expected 1", c, tx_a); end
      n_checks++; if (ax_a.rdy !== 1'b1) begin n_fail++; $display("FAIL t4_rdy cycle %0d: got %b expected 1", c, ax_a.rdy); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t4_busy cycle %0d: got %b expected 0", c, busy_a); end
    end
  endtask

  task automatic test_two_stop;
    int lo, hi;
    lo = 0; hi = 0;
    @(negedge clk);
    ax_b.data = 8'h00; ax_b.vld = 1'b1;
    @(negedge clk);
    ax_b.vld = 1'b0;
    for (int c = 0; c < FRAME_B; c++) begin
      if (tx_b === 1'b0) lo++; else hi++;
      n_checks++;
      if (tx_b !== exp_bit(8'h00, c / CPB)) begin n_fail++; $display("FAIL t5_tx cycle %0d: got %b expected %b", c, tx_b, exp_bit(8'h00, c / CPB)); end
      @(negedge clk);
    end
    n_checks++; if (lo != 90 + P * CPB) begin n_fail++; $display("FAIL t5_low_count: got %0d expected %0d", lo, 90 + P * CPB); end
    n_checks++; if (hi != 20) begin n_fail++; $display("FAIL t5_high_count: got %0d expected 20", hi); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL t5_busy_end: got %b expected 0", busy_b); end
  endtask

`ifdef AXIS_UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] vec [2];
    logic       par [2];
    vec[0] = 8'h07; par[0] = 1'b1;
    vec[1] = 8'h03; par[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      ax_a.data = vec[v]; ax_a.vld = 1'b1;
      @(negedge clk);
      ax_a.vld = 1'b0;
      for (int c = 0; c < 110; c++) begin
        if ((c >= 90) && (c < 100)) begin
          n_checks++;
          if (tx_a !== par[v]) begin n_fail++; $display("FAIL t6_parity byte %h cycle %0d: got %b expected %b", vec[v], c, tx_a, par[v]); end
        end
        n_checks++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL t6_busy cycle %0d: got %b expected 1", c, busy_a); end
        @(negedge clk);
      end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t6_frame_len: got busy %b expected 0", busy_a); end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    ax_a.data = 8'h00; ax_a.vld = 1'b0;
    ax_b.data = 8'h00; ax_b.vld = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_idle_hold();
    test_two_stop();
`ifdef AXIS_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
